mux_81: RTL and testbench

- 8-to-1 single-bit multiplexer with a 3-bit select split across three scalar pins.
- Combinational output y for direct use.
- Registered copy of the output and the select index for downstream synchronous logic.
- Used as a bit-select leaf cell in datapath steering logic.

---
 rtl/mux_81_if.sv | 30 +++
 rtl/mux_81.sv | 89 ++++++++
 tb/tb_mux_81.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mux_81_if.sv
// mux_81_if: bus bundle for the mux_81 bit-select leaf cell.
//   i[8:0]      data lanes (i[8] reserved, ignored)
//   s0/s1/s2    select pins, s0 is the index MSB
//   en          capture enable for the registered outputs
//   y           combinational mux output
//   y_q         registered mux output
//   sel_q[2:0]  registered select index
//   err         one-hot check flag
// master drives data/select/enable, slave (the mux) drives the results.
interface mux_81_if;
    logic [8:0] i;
    logic       s0;
    logic       s1;
    logic       s2;
    logic       en;
    logic       y;
    logic       y_q;
    logic [2:0] sel_q;
    logic       err;

    modport master (
        output i, s0, s1, s2, en,
        input  y, y_q, sel_q, err
    );

    modport slave (
        input  i, s0, s1, s2, en,
        output y, y_q, sel_q, err
    );
endinterface

// File: rtl/mux_81.sv
// mux_81: 8-to-1 single-bit multiplexer with registered copies of the
// result and the select index.
//   clk   rising-edge clock for the registered outputs
//   rst   asynchronous reset, active-high
//   bus   mux_81_if.slave: i, s0..s2, en in; y, y_q, sel_q, err out
// Parameter RST_VAL is the reset value of y_q.
// Optional macro MUX_81_ONEHOT_CHK_EN builds a registered flag that is set
// when the captured i[7:0] is not exactly one-hot; without it err is 0.
module mux_81 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    mux_81_if.slave       bus
);
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned LANE_W = 8;

    logic [LANE_W-1:0] lanes;
    logic [SEL_W-1:0]  sel;
    logic              y_mux;
    logic              y_d;
    logic              y_q;
    logic [SEL_W-1:0]  sel_d;
    logic [SEL_W-1:0]  sel_q;
    logic              unused_rsvd;

    // Reserved lane bit is deliberately ignored.
    assign unused_rsvd = bus.i[8];

    // Select decode and combinational mux; s0 is the MSB.
    always_comb begin
        lanes = bus.i[LANE_W-1:0];
        sel   = {bus.s0, bus.s1, bus.s2};
        y_mux = lanes[sel];
    end

    // Capture on enable, otherwise hold.
    always_comb begin
        y_d   = y_q;
        sel_d = sel_q;
        if (bus.en) begin
            y_d   = y_mux;
            sel_d = sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q   <= RST_VAL;
            sel_q <= '0;
        end else begin
            y_q   <= y_d;
            sel_q <= sel_d;
        end
    end

    assign bus.y     = y_mux;
    assign bus.y_q   = y_q;
    assign bus.sel_q = sel_q;

`ifdef MUX_81_ONEHOT_CHK_EN
    logic onehot;
    logic err_d;
    logic err_q;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    always_comb begin
        onehot = (lanes != '0) && ((lanes & (lanes - LANE_W'(1))) == '0);
        err_d  = err_q;
        if (bus.en) begin
            err_d = ~onehot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_81.sv
// tb_mux_81: directed and randomized checks of mux_81 against a behavioural
// model (shift-based lane pick, popcount-based one-hot test).
module tb_mux_81;
    localparam logic RST_VAL = 1'b0;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic       exp_yq;
    logic [2:0] exp_selq;
    logic       exp_err;

    mux_81_if bus();

    mux_81 #(.RST_VAL(RST_VAL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ref_y(input logic [8:0] iv, input logic [2:0] sv);
        logic [7:0] lanes;
        lanes = iv[7:0] >> sv;
        return lanes[0];
    endfunction

    function automatic logic ref_err(input logic [8:0] iv);
`ifdef MUX_81_ONEHOT_CHK_EN
        return $countones(iv[7:0]) != 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input logic [8:0] iv, input logic [2:0] sv, input logic ev);
        bus.i  = iv;
        {bus.s0, bus.s1, bus.s2} = sv;
        bus.en = ev;
    endtask

    task automatic model_reset();
        exp_yq   = RST_VAL;
        exp_selq = 3'd0;
        exp_err  = 1'b0;
    endtask

    // Advance one clock; the model captures the inputs present at the edge.
    task automatic clk_step();
        logic [2:0] sv;
        sv = {bus.s0, bus.s1, bus.s2};
        @(posedge clk);
        if (!rst && bus.en) begin
            exp_yq   = ref_y(bus.i, sv);
            exp_selq = sv;
            exp_err  = ref_err(bus.i);
        end
        #1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_yq"},  32'(bus.y_q),   32'(exp_yq));
        check({tag, "_sel"}, 32'(bus.sel_q), 32'(exp_selq));
        check({tag, "_err"}, 32'(bus.err),   32'(exp_err));
    endtask

    // Reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_regs(tag);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [8:0] iv;
        logic [2:0] sv;
        logic       ev;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(9'h000, 3'd0, 1'b0);
        model_reset();
        #2;
        check_regs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Combinational sweep with registers idle.
        for (int s = 0; s < 8; s++) begin
            sv = 3'(s);
            drive(9'(1) << s, sv, 1'b0);
            #1;
            check($sformatf("sweep_hit%0d", s), 32'(bus.y), 32'd1);
            drive(9'(1) << ((s + 3) % 8), sv, 1'b0);
            #1;
            check($sformatf("sweep_miss%0d", s), 32'(bus.y), 32'd0);
        end

        // Reserved bit must never reach the output.
        drive(9'h100, 3'd0, 1'b1);
        #1;
        check("rsvd_y", 32'(bus.y), 32'd0);
        clk_step();
        check("rsvd_yq", 32'(bus.y_q), 32'd0);

        // Register path.
        async_reset("rst1");
        drive(9'h020, 3'd5, 1'b1);
        clk_step();
        check("cap_yq", 32'(bus.y_q), 32'd1);
        check("cap_sel", 32'(bus.sel_q), 32'd5);
        check_regs("cap");

        // Enable low holds registers, y follows inputs immediately.
        drive(9'h000, 3'd5, 1'b0);
        #1;
        check("hold_y", 32'(bus.y), 32'd0);
        clk_step();
        check("hold_yq", 32'(bus.y_q), 32'd1);
        check("hold_sel", 32'(bus.sel_q), 32'd5);

        // Asynchronous reset while y_q is high.
        async_reset("arst");
        check("arst_yq", 32'(bus.y_q), 32'(RST_VAL));

        // One-hot flag sequence.
        drive(9'h003, 3'd1, 1'b1);
        clk_step();
        check_regs("oh3");
        drive(9'h004, 3'd2, 1'b1);
        clk_step();
        check_regs("oh4");
        drive(9'h000, 3'd2, 1'b1);
        clk_step();
        check_regs("oh0");
`ifdef MUX_81_ONEHOT_CHK_EN
        check("oh0_flag", 32'(bus.err), 32'd1);
`else
        check("err_tied", 32'(bus.err), 32'd0);
`endif

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 300; n++) begin
            sv = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0)
                iv = {1'($urandom_range(0, 1)), 8'(1) << $urandom_range(0, 7)};
            else
                iv = 9'($urandom);
            ev = ($urandom_range(0, 3) != 0);
            drive(iv, sv, ev);
            #1;
            check($sformatf("rnd_y%0d", n), 32'(bus.y), 32'(ref_y(iv, sv)));
            clk_step();
            check_regs($sformatf("rnd%0d", n));
            if ($urandom_range(0, 19) == 0)
                async_reset($sformatf("rnd_rst%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
